// File: rtl/frame_fifo_writer.sv
// Write-side producer for the dual-clock frame FIFO: enforces sop/eop framing,
// applies FIFO backpressure, truncates over-length frames and keeps statistics.
module frame_fifo_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LEN    = 256,
    parameter int LEN_WIDTH  = 9,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  wclk,
    input  logic                  rst_n,
    input  logic                  sw_rst,
    input  logic                  enable,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sop,
    input  logic                  in_eop,
    input  logic                  fifo_almost_full,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    output logic                  fifo_sop,
    output logic                  fifo_eop,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  frame_cnt,
    output logic [CNT_WIDTH-1:0]  trunc_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0] LEN_LAST = LEN_WIDTH'(MAX_LEN - 1);

    state_t                  state_r;
    state_t                  state_s;
    logic [LEN_WIDTH-1:0]    len_r;
    logic [LEN_WIDTH-1:0]    len_s;
    logic                    in_ready_s;
    logic                    accept_s;
    logic                    write_s;
    logic                    wr_sop_s;
    logic                    wr_eop_s;
    logic                    frame_inc_s;
    logic                    trunc_inc_s;
    logic                    err_inc_s;

    logic                    fifo_wr_en_r;
    logic [DATA_WIDTH-1:0]   fifo_wr_data_r;
    logic                    fifo_sop_r;
    logic                    fifo_eop_r;
    logic                    busy_r;
    logic [CNT_WIDTH-1:0]    frame_cnt_r;
    logic [CNT_WIDTH-1:0]    trunc_cnt_r;
    logic [CNT_WIDTH-1:0]    err_cnt_r;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] cnt,
        input logic                 inc
    );
        if (inc && (cnt != {CNT_WIDTH{1'b1}})) begin
            return cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            return cnt;
        end
    endfunction

    // Ready generation: DROP swallows words without needing FIFO space.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            ST_IDLE: in_ready_s = enable && !fifo_almost_full && !fifo_full;
            ST_PASS: in_ready_s = !fifo_almost_full && !fifo_full;
            ST_DROP: in_ready_s = 1'b1;
            default: in_ready_s = 1'b0;
        endcase
    end

    assign accept_s = in_valid && in_ready_s;

    // Next-state, write decision and counter-increment decode.
    always_comb begin
        state_s     = state_r;
        len_s       = len_r;
        write_s     = 1'b0;
        wr_sop_s    = 1'b0;
        wr_eop_s    = 1'b0;
        frame_inc_s = 1'b0;
        trunc_inc_s = 1'b0;
        err_inc_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && in_sop) begin
                    write_s  = 1'b1;
                    wr_sop_s = 1'b1;
                    if (in_eop) begin
                        wr_eop_s    = 1'b1;
                        frame_inc_s = 1'b1;
                    end else begin
                        state_s = ST_PASS;
                        len_s   = LEN_ONE;
                    end
                end else if (accept_s) begin
                    err_inc_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PASS: begin
                if (accept_s) begin
                    write_s   = 1'b1;
                    err_inc_s = in_sop;
                    if (in_eop) begin
                        wr_eop_s    = 1'b1;
                        frame_inc_s = 1'b1;
                        state_s     = ST_IDLE;
                        len_s       = LEN_ZERO;
                    end else if (len_r == LEN_LAST) begin
                        // Frame hit MAX_LEN: close it here and discard the tail.
                        wr_eop_s    = 1'b1;
                        frame_inc_s = 1'b1;
                        trunc_inc_s = 1'b1;
                        state_s     = ST_DROP;
                        len_s       = LEN_ZERO;
                    end else begin
                        len_s = len_r + LEN_ONE;
                    end
                end else begin
                    state_s = ST_PASS;
                end
            end
            ST_DROP: begin
                if (accept_s && in_eop) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DROP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                len_s   = LEN_ZERO;
            end
        endcase
    end

    // State, output register and statistics; sw_rst mirrors rst_n synchronously.
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            len_r          <= LEN_ZERO;
            fifo_wr_en_r   <= 1'b0;
            fifo_wr_data_r <= {DATA_WIDTH{1'b0}};
            fifo_sop_r     <= 1'b0;
            fifo_eop_r     <= 1'b0;
            busy_r         <= 1'b0;
            frame_cnt_r    <= {CNT_WIDTH{1'b0}};
            trunc_cnt_r    <= {CNT_WIDTH{1'b0}};
            err_cnt_r      <= {CNT_WIDTH{1'b0}};
        end else if (sw_rst) begin
            state_r        <= ST_IDLE;
            len_r          <= LEN_ZERO;
            fifo_wr_en_r   <= 1'b0;
            fifo_wr_data_r <= {DATA_WIDTH{1'b0}};
            fifo_sop_r     <= 1'b0;
            fifo_eop_r     <= 1'b0;
            busy_r         <= 1'b0;
            frame_cnt_r    <= {CNT_WIDTH{1'b0}};
            trunc_cnt_r    <= {CNT_WIDTH{1'b0}};
            err_cnt_r      <= {CNT_WIDTH{1'b0}};
        end else begin
            state_r      <= state_s;
            len_r        <= len_s;
            fifo_wr_en_r <= write_s;
            fifo_sop_r   <= wr_sop_s;
            fifo_eop_r   <= wr_eop_s;
            busy_r       <= (state_s != ST_IDLE);
            frame_cnt_r  <= sat_inc(frame_cnt_r, frame_inc_s);
            trunc_cnt_r  <= sat_inc(trunc_cnt_r, trunc_inc_s);
            err_cnt_r    <= sat_inc(err_cnt_r, err_inc_s);
            if (write_s) begin
                fifo_wr_data_r <= in_data;
            end
        end
    end

    assign in_ready     = in_ready_s;
    assign fifo_wr_en   = fifo_wr_en_r;
    assign fifo_wr_data = fifo_wr_data_r;
    assign fifo_sop     = fifo_sop_r;
    assign fifo_eop     = fifo_eop_r;
    assign busy         = busy_r;
    assign frame_cnt    = frame_cnt_r;
    assign trunc_cnt    = trunc_cnt_r;
    assign err_cnt      = err_cnt_r;

endmodule
